// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared types and defaults for the branch predictor update path
package riscv_defines;

  localparam int BP_ENTRIES_DEFAULT = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bp_upd_t;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } bp_ctrl_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO of predictor updates with flush
module bp_upd_fifo
  import riscv_defines::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  bp_upd_t                  push_data,
  input  logic                     pop,
  output bp_upd_t                  pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  bp_upd_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - BHT/BTB write sequencer: mispredict redirect, update FIFO, entry-clear walk
// Optional stat_cflow/stat_mispred counters built when BP_UPDATE_STATS_EN is defined.
module bp_update_ctrl
  import riscv_defines::*;
#(
  parameter int ENTRIES    = BP_ENTRIES_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_req,
  input  logic                       ex_cflow_valid,
  input  logic [31:0]                ex_pc,
  input  logic                       ex_taken,
  input  logic [31:0]                ex_target,
  input  logic                       ex_pred_taken,
  input  logic [31:0]                ex_pred_target,
  output logic                       ex_stall,
  output logic                       mispredict,
  output logic [31:0]                redirect_pc,
  output logic                       upd_valid,
  output logic [31:0]                upd_pc,
  output logic                       upd_taken,
  output logic [31:0]                upd_target,
  output logic                       clr_valid,
  output logic [$clog2(ENTRIES)-1:0] clr_index,
  output logic                       busy
`ifdef BP_UPDATE_STATS_EN
  ,
  output logic [31:0]                stat_cflow,
  output logic [31:0]                stat_mispred
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bp_ctrl_state_t  state, state_nxt;
  logic [IW-1:0]   clr_idx, clr_idx_nxt;

  bp_upd_t         fifo_head;
  bp_upd_t         fifo_in;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            enq;
  logic            push;
  logic            pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    ex_stall    = 1'b0;
    enq         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    mispredict  = 1'b0;
    redirect_pc = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
    clr_valid   = 1'b0;
    clr_index   = '0;
    busy        = 1'b1;

    case (state)
      S_CLEAR: begin
        if (clr_idx == IW'(ENTRIES - 1)) begin
          state_nxt   = S_IDLE;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + 1'b1;
        end
      end
      default: ;
    endcase
    if (flush_req) begin
      state_nxt   = S_CLEAR;
      clr_idx_nxt = '0;
    end

    // Everything visible stays quiet while reset is held; only busy reports activity.
    if (!reset) begin
      ex_stall    = ex_cflow_valid && fifo_full;
      enq         = ex_cflow_valid && !ex_stall;
      push        = enq && !flush_req;
      mispredict  = enq && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && (ex_target != ex_pred_target)));
      redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      pop         = (state == S_IDLE) && !fifo_empty;
      upd_valid   = pop;
      if (pop) begin
        upd_pc     = fifo_head.pc;
        upd_taken  = fifo_head.taken;
        upd_target = fifo_head.target;
      end
      clr_valid   = (state == S_CLEAR);
      clr_index   = clr_idx;
      busy        = (state == S_CLEAR) || !fifo_empty;
    end
  end

  assign fifo_in = '{pc: ex_pc, taken: ex_taken, target: ex_target};

  bp_upd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush_req),
    .push     (push),
    .push_data(fifo_in),
    .pop      (pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef BP_UPDATE_STATS_EN
  logic [31:0] cflow_cnt;
  logic [31:0] mispred_cnt;

  // Saturating; flush_req deliberately leaves these alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      cflow_cnt   <= '0;
      mispred_cnt <= '0;
    end else begin
      if (push && (cflow_cnt != 32'hFFFF_FFFF))         cflow_cnt   <= cflow_cnt + 32'd1;
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  assign stat_cflow   = reset ? '0 : cflow_cnt;
  assign stat_mispred = reset ? '0 : mispred_cnt;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - directed self-checking bench for bp_update_ctrl
module tb_bp_update_ctrl;

  logic        clk;
  logic        reset;
  logic        flush_req;
  logic        ex_cflow_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_stall;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        clr_valid;
  logic [5:0]  clr_index;
  logic        busy;
`ifdef BP_UPDATE_STATS_EN
  logic [31:0] stat_cflow;
  logic [31:0] stat_mispred;
`endif

  int n_total;
  int n_pass;

  bp_update_ctrl #(
    .ENTRIES   (64),
    .FIFO_DEPTH(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_req     (flush_req),
    .ex_cflow_valid(ex_cflow_valid),
    .ex_pc         (ex_pc),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .ex_pred_taken (ex_pred_taken),
    .ex_pred_target(ex_pred_target),
    .ex_stall      (ex_stall),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .clr_valid     (clr_valid),
    .clr_index     (clr_index),
    .busy          (busy)
`ifdef BP_UPDATE_STATS_EN
    ,
    .stat_cflow    (stat_cflow),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
    ex_cflow_valid = v;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  int          stall_cnt, mp_cnt, clr_cnt, upd_cnt, overlap;
  logic        held, s;
  logic [31:0] upd_q[$];

  initial begin
    n_total = 0; n_pass = 0;
    reset = 1'b1; flush_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // outputs gated while reset is held, even with a mispredicting cflow present
    drive(1, 32'h10, 1, 32'h80, 0, 32'h0);
    #1;
    chk("rst_mispredict", mispredict, 0);
    chk("rst_stall", ex_stall, 0);
    chk("rst_clr_valid", clr_valid, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_redirect", redirect_pc, 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // post-reset clear walk over 64 entries
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("walk_clr_valid", clr_valid, 1);
      chk("walk_clr_index", clr_index, i);
      chk("walk_upd_valid", upd_valid, 0);
      chk("walk_busy", busy, 1);
      tick();
    end
    #1;
    chk("walk_end_clr_valid", clr_valid, 0);
    chk("walk_end_busy", busy, 0);

    // correct prediction, one-cycle enqueue-to-update latency
    drive(1, 32'h100, 1, 32'h200, 1, 32'h200);
    #1;
    chk("idle_mispredict", mispredict, 0);
    chk("idle_stall", ex_stall, 0);
    chk("idle_upd_same_cycle", upd_valid, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("idle_upd_valid", upd_valid, 1);
    chk("idle_upd_pc", upd_pc, 32'h100);
    chk("idle_upd_taken", upd_taken, 1);
    chk("idle_upd_target", upd_target, 32'h200);
    tick();
    #1;
    chk("idle_drained", upd_valid, 0);
    chk("idle_busy", busy, 0);

    // direction mispredict, fall-through wraps past 2^32
    drive(1, 32'hFFFF_FFFC, 0, 32'h1234, 1, 32'h1234);
    #1;
    chk("wrap_mispredict", mispredict, 1);
    chk("wrap_redirect", redirect_pc, 32'h0000_0000);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_upd_pc", upd_pc, 32'hFFFF_FFFC);
    chk("wrap_upd_taken", upd_taken, 0);

    // target mispredict on a correctly predicted taken branch
    drive(1, 32'h40, 1, 32'h300, 1, 32'h200);
    #1;
    chk("tgt_mispredict", mispredict, 1);
    chk("tgt_redirect", redirect_pc, 32'h300);
    tick();
    // not-taken predicted not-taken: targets irrelevant
    drive(1, 32'h50, 0, 32'h11, 0, 32'h22);
    #1;
    chk("nt_mispredict", mispredict, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // five back-to-back cflow during a clear walk; fifth stalls until walk ends
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h1000 + 32'(16 * k), 1, 32'h2000 + 32'(k), 1, 32'h2000 + 32'(k));
      #1;
      chk("fill_stall", ex_stall, 0);
      chk("fill_mispredict", mispredict, 0);
      chk("fill_clr_valid", clr_valid, 1);
      tick();
    end
    drive(1, 32'h1040, 0, 32'h2004, 1, 32'h2004);
    stall_cnt = 0; mp_cnt = 0; clr_cnt = 0; overlap = 0; held = 1'b1;
    upd_q.delete();
    for (int c = 4; c <= 70; c++) begin
      #1;
      if (ex_stall)   stall_cnt++;
      if (mispredict) mp_cnt++;
      if (clr_valid)  clr_cnt++;
      if (upd_valid) begin
        if (clr_valid) overlap++;
        upd_q.push_back(upd_pc);
      end
      s = ex_stall;
      tick();
      if (held && !s) begin
        held = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
      end
    end
    chk("hold_stall_cycles", stall_cnt, 61);
    chk("hold_mispredict_once", mp_cnt, 1);
    chk("hold_clr_cycles", clr_cnt, 60);
    chk("hold_upd_during_clr", overlap, 0);
    chk("hold_upd_count", upd_q.size(), 5);
    for (int i = 0; i < upd_q.size() && i < 5; i++)
      chk("hold_upd_order", upd_q[i], 32'h1000 + 32'(16 * i));
    #1;
    chk("hold_busy_end", busy, 0);

    // flush mid-walk at index 20 with two pending updates
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    drive(1, 32'hA0, 1, 32'hA8, 1, 32'hA8);
    tick();
    drive(1, 32'hB0, 1, 32'hB8, 1, 32'hB8);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 20; i++) tick();
    #1;
    chk("flush_at_index", clr_index, 20);
    chk("flush_busy_pending", busy, 1);
    flush_req = 1'b1;
    drive(1, 32'hC0, 1, 32'hC8, 0, 32'h0);
    #1;
    chk("flush_mispredict", mispredict, 1);
    tick();
    flush_req = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    clr_cnt = 0; upd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (clr_valid) clr_cnt++;
      if (upd_valid) upd_cnt++;
      if (i == 0)  chk("restart_index0", clr_index, 0);
      if (i == 63) chk("restart_index63", clr_index, 63);
      tick();
    end
    #1;
    chk("restart_clr_cycles", clr_cnt, 64);
    chk("restart_no_stale_upd", upd_cnt, 0);
    chk("restart_end_clr_valid", clr_valid, 0);
    chk("restart_end_upd_valid", upd_valid, 0);
    chk("restart_end_busy", busy, 0);

`ifdef BP_UPDATE_STATS_EN
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h300 + 32'(4 * k), 1, 32'h400, 1,
            (k == 2 || k == 5 || k == 8) ? 32'h500 : 32'h400);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    #1;
    chk("stat_cflow", stat_cflow, 10);
    chk("stat_mispred", stat_mispred, 3);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    #1;
    chk("stat_cflow_after_flush", stat_cflow, 10);
    chk("stat_mispred_after_flush", stat_mispred, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
